// File: rtl/lock_supervisor_if.sv
// Digit handshake between input conditioning and the lock supervisor.
// Master drives a digit and strobe; slave answers with ready.
interface lock_supervisor_if #(
    parameter int DIGIT_W = 4
);
    logic [DIGIT_W-1:0] digit_in;
    logic               digit_valid;
    logic               digit_ready;

    modport master (
        output digit_in,
        output digit_valid,
        input  digit_ready
    );

    modport slave (
        input  digit_in,
        input  digit_valid,
        output digit_ready
    );
endinterface

// File: rtl/lock_supervisor.sv
// Combination-lock sequencer: six-digit entry, failed-attempt lockout,
// and enter-then-confirm reprogramming of the stored code while open.
module lock_supervisor #(
    parameter int NUM_DIGITS     = 6,
    parameter int DIGIT_W        = 4,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 50,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 24'h611371
) (
    input  logic                             clk,
    input  logic                             rst_n,
    lock_supervisor_if.slave                 dif,
    input  logic                             relock,
    input  logic                             prog_req,
    output logic                             open,
    output logic                             locked_out,
    output logic                             prog_done,
    output logic                             prog_err,
    output logic [2:0]                       digit_index,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count,
    output logic [2:0]                       state_out
);

    localparam int FCW = $clog2(MAX_FAILS + 1);
    localparam int TW  = $clog2(LOCKOUT_CYCLES + 1);
    localparam int IW  = 3;

    localparam logic [IW-1:0]  LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [FCW-1:0] FMAX  = FCW'(MAX_FAILS);
    localparam logic [TW-1:0]  TLOAD = TW'(LOCKOUT_CYCLES);
    localparam logic [TW-1:0]  TONE  = TW'(1);

    typedef enum logic [2:0] {
        S_ENTRY = 3'd0,
        S_EVAL  = 3'd1,
        S_OPEN  = 3'd2,
        S_LOCK  = 3'd3,
        S_PROG  = 3'd4,
        S_CONF  = 3'd5
    } state_t;

    state_t                              r_state;
    logic [IW-1:0]                       r_idx;
    logic                                r_mm;
    logic [FCW-1:0]                      r_fail;
    logic [TW-1:0]                       r_timer;
    logic                                r_done;
    logic                                r_err;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  r_code;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  r_shadow;

    logic [IW-1:0]  w_pos;
    logic           w_last;
    logic           w_acc;
    logic           w_diff_code;
    logic           w_diff_sh;
    logic [FCW-1:0] w_fail_inc;

    // Digit 0 lives in the most significant nibble, so the
    // array element is the reversed index.
    assign w_pos       = LAST - r_idx;
    assign w_last      = (r_idx == LAST);
    assign w_acc       = dif.digit_valid & dif.digit_ready;
    assign w_diff_code = (dif.digit_in != r_code[w_pos]);
    assign w_diff_sh   = (dif.digit_in != r_shadow[w_pos]);
    assign w_fail_inc  = r_fail + 1'b1;

    assign dif.digit_ready = (r_state == S_ENTRY) |
                             (r_state == S_PROG)  |
                             (r_state == S_CONF);
    assign open        = (r_state == S_OPEN);
    assign locked_out  = (r_state == S_LOCK);
    assign prog_done   = r_done;
    assign prog_err    = r_err;
    assign digit_index = r_idx;
    assign fail_count  = r_fail;
    assign state_out   = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_ENTRY;
            r_idx    <= '0;
            r_mm     <= 1'b0;
            r_fail   <= '0;
            r_timer  <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_code   <= DEFAULT_CODE;
            r_shadow <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                S_ENTRY: begin
                    if (w_acc) begin
                        r_mm <= r_mm | w_diff_code;
                        if (w_last) begin
                            r_idx   <= '0;
                            r_state <= S_EVAL;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                S_EVAL: begin
                    r_mm <= 1'b0;
                    if (!r_mm) begin
                        r_fail  <= '0;
                        r_state <= S_OPEN;
                    end else if (w_fail_inc == FMAX) begin
                        r_fail  <= FMAX;
                        r_timer <= TLOAD;
                        r_state <= S_LOCK;
                    end else begin
                        r_fail  <= w_fail_inc;
                        r_state <= S_ENTRY;
                    end
                end
                S_OPEN: begin
                    if (relock) begin
                        r_state <= S_ENTRY;
                    end else if (prog_req) begin
                        r_idx   <= '0;
                        r_mm    <= 1'b0;
                        r_state <= S_PROG;
                    end
                end
                S_LOCK: begin
                    if (r_timer == TONE) begin
                        r_timer <= '0;
                        r_fail  <= '0;
                        r_state <= S_ENTRY;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_PROG: begin
                    if (relock) begin
                        r_idx   <= '0;
                        r_mm    <= 1'b0;
                        r_state <= S_ENTRY;
                    end else if (w_acc) begin
                        r_shadow[w_pos] <= dif.digit_in;
                        if (w_last) begin
                            r_idx   <= '0;
                            r_state <= S_CONF;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                S_CONF: begin
                    if (relock) begin
                        r_idx   <= '0;
                        r_mm    <= 1'b0;
                        r_state <= S_ENTRY;
                    end else if (w_acc) begin
                        if (w_last) begin
                            r_idx   <= '0;
                            r_mm    <= 1'b0;
                            r_state <= S_OPEN;
                            if (!(r_mm | w_diff_sh)) begin
                                r_code <= r_shadow;
                                r_done <= 1'b1;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end else begin
                            r_mm  <= r_mm | w_diff_sh;
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_idx   <= '0;
                    r_mm    <= 1'b0;
                    r_state <= S_ENTRY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_supervisor.sv
// Self-checking bench for lock_supervisor: per-cycle vector tables
// with a scoreboard queue, plus asynchronous reset corner cases.
module tb_lock_supervisor;

    logic       clk;
    logic       rst_n;
    logic       relock;
    logic       prog_req;
    logic       open;
    logic       locked_out;
    logic       prog_done;
    logic       prog_err;
    logic [2:0] digit_index;
    logic [1:0] fail_count;
    logic [2:0] state_out;

    int checks = 0;
    int errors = 0;
    int vec_no = 0;

    lock_supervisor_if #(.DIGIT_W(4)) dif ();

    lock_supervisor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dif         (dif),
        .relock      (relock),
        .prog_req    (prog_req),
        .open        (open),
        .locked_out  (locked_out),
        .prog_done   (prog_done),
        .prog_err    (prog_err),
        .digit_index (digit_index),
        .fail_count  (fail_count),
        .state_out   (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        logic       v;
        logic       rl;
        logic       pr;
        logic [2:0] st;
        logic [2:0] idx;
        logic [1:0] fl;
        logic       dn;
        logic       er;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic void add(input logic [3:0] d, input logic v,
                                input logic rl, input logic pr,
                                input logic [2:0] st, input logic [2:0] idx,
                                input logic [1:0] fl, input logic dn,
                                input logic er);
        vec_t x;
        x.d = d; x.v = v; x.rl = rl; x.pr = pr;
        x.st = st; x.idx = idx; x.fl = fl; x.dn = dn; x.er = er;
        tbl.push_back(x);
    endfunction

    function automatic void idle(input logic rl, input logic pr,
                                 input logic [2:0] st, input logic [1:0] fl,
                                 input logic dn, input logic er);
        add(4'h0, 1'b0, rl, pr, st, 3'd0, fl, dn, er);
    endfunction

    // Six digits, MS nibble first; st_in while collecting, st_end after last.
    function automatic void code6(input logic [23:0] c,
                                  input logic [2:0] st_in,
                                  input logic [2:0] st_end,
                                  input logic [1:0] fl,
                                  input logic dn, input logic er);
        for (int i = 0; i < 6; i++) begin
            if (i == 5)
                add(c[(5-i)*4 +: 4], 1'b1, 1'b0, 1'b0, st_end, 3'd0, fl, dn, er);
            else
                add(c[(5-i)*4 +: 4], 1'b1, 1'b0, 1'b0, st_in,
                    3'(i + 1), fl, 1'b0, 1'b0);
        end
    endfunction

    task automatic check_one();
        vec_t e;
        logic [12:0] exp_v;
        logic [12:0] act_v;
        logic        e_rdy;
        e = sb.pop_front();
        e_rdy = (e.st == 3'd0) || (e.st == 3'd4) || (e.st == 3'd5);
        exp_v = {e.st == 3'd2, e.st == 3'd3, e_rdy, e.idx, e.fl,
                 e.st, e.dn, e.er};
        act_v = {open, locked_out, dif.digit_ready, digit_index,
                 fail_count, state_out, prog_done, prog_err};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL vec%0d {open,lo,rdy,idx,fail,st,done,err} got=%b expected=%b",
                     vec_no, act_v, exp_v);
        end
        vec_no++;
    endtask

    task automatic expect_reset();
        vec_t e;
        e.d = '0; e.v = 0; e.rl = 0; e.pr = 0;
        e.st = 3'd0; e.idx = 3'd0; e.fl = 2'd0; e.dn = 0; e.er = 0;
        sb.push_back(e);
        check_one();
    endtask

    task automatic run_tbl();
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            dif.digit_in    = tbl[i].d;
            dif.digit_valid = tbl[i].v;
            relock          = tbl[i].rl;
            prog_req        = tbl[i].pr;
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1;
            check_one();
        end
        tbl.delete();
        dif.digit_valid = 1'b0;
        relock          = 1'b0;
        prog_req        = 1'b0;
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        expect_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n           = 1'b0;
        dif.digit_in    = '0;
        dif.digit_valid = 1'b0;
        relock          = 1'b0;
        prog_req        = 1'b0;
        #3;
        expect_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // correct code, wrong codes, lockout
        code6(24'h611371, 3'd0, 3'd1, 2'd0, 0, 0);
        idle(0, 0, 3'd2, 2'd0, 0, 0);
        idle(1, 0, 3'd0, 2'd0, 0, 0);
        code6(24'h612371, 3'd0, 3'd1, 2'd0, 0, 0);
        idle(0, 0, 3'd0, 2'd1, 0, 0);
        code6(24'h612371, 3'd0, 3'd1, 2'd1, 0, 0);
        idle(0, 0, 3'd0, 2'd2, 0, 0);
        code6(24'h612371, 3'd0, 3'd1, 2'd2, 0, 0);
        idle(0, 0, 3'd3, 2'd3, 0, 0);
        for (int k = 1; k < 50; k++) begin
            add(4'h6, 1'b1, 1'(k & 1), 1'((k >> 1) & 1),
                3'd3, 3'd0, 2'd3, 0, 0);
        end
        idle(0, 0, 3'd0, 2'd0, 0, 0);
        code6(24'h611371, 3'd0, 3'd1, 2'd0, 0, 0);
        idle(0, 0, 3'd2, 2'd0, 0, 0);

        // confirm mismatch keeps old code
        idle(0, 1, 3'd4, 2'd0, 0, 0);
        code6(24'h246809, 3'd4, 3'd5, 2'd0, 0, 0);
        code6(24'h246800, 3'd5, 3'd2, 2'd0, 0, 1);
        idle(0, 0, 3'd2, 2'd0, 0, 0);
        idle(1, 0, 3'd0, 2'd0, 0, 0);
        code6(24'h611371, 3'd0, 3'd1, 2'd0, 0, 0);
        idle(0, 0, 3'd2, 2'd0, 0, 0);

        // abort mid-programming with a digit in the same cycle
        idle(0, 1, 3'd4, 2'd0, 0, 0);
        add(4'h2, 1, 0, 0, 3'd4, 3'd1, 2'd0, 0, 0);
        add(4'h4, 1, 0, 0, 3'd4, 3'd2, 2'd0, 0, 0);
        add(4'h6, 1, 1, 0, 3'd0, 3'd0, 2'd0, 0, 0);
        idle(0, 0, 3'd0, 2'd0, 0, 0);
        code6(24'h611371, 3'd0, 3'd1, 2'd0, 0, 0);
        idle(0, 0, 3'd2, 2'd0, 0, 0);

        // relock beats prog_req in OPEN
        idle(1, 1, 3'd0, 2'd0, 0, 0);
        code6(24'h611371, 3'd0, 3'd1, 2'd0, 0, 0);
        idle(0, 0, 3'd2, 2'd0, 0, 0);

        // successful reprogramming
        idle(0, 1, 3'd4, 2'd0, 0, 0);
        code6(24'h246809, 3'd4, 3'd5, 2'd0, 0, 0);
        code6(24'h246809, 3'd5, 3'd2, 2'd0, 1, 0);
        idle(0, 0, 3'd2, 2'd0, 0, 0);
        idle(1, 0, 3'd0, 2'd0, 0, 0);
        code6(24'h611371, 3'd0, 3'd1, 2'd0, 0, 0);
        idle(0, 0, 3'd0, 2'd1, 0, 0);
        code6(24'h246809, 3'd0, 3'd1, 2'd1, 0, 0);
        idle(0, 0, 3'd2, 2'd0, 0, 0);

        // drive into lockout with the new code stored
        idle(1, 0, 3'd0, 2'd0, 0, 0);
        code6(24'h611371, 3'd0, 3'd1, 2'd0, 0, 0);
        idle(0, 0, 3'd0, 2'd1, 0, 0);
        code6(24'h611371, 3'd0, 3'd1, 2'd1, 0, 0);
        idle(0, 0, 3'd0, 2'd2, 0, 0);
        code6(24'h611371, 3'd0, 3'd1, 2'd2, 0, 0);
        idle(0, 0, 3'd3, 2'd3, 0, 0);
        for (int k = 0; k < 10; k++) idle(0, 0, 3'd3, 2'd3, 0, 0);
        run_tbl();
        async_reset();

        // default code restored; then reset mid-confirm
        code6(24'h611371, 3'd0, 3'd1, 2'd0, 0, 0);
        idle(0, 0, 3'd2, 2'd0, 0, 0);
        idle(0, 1, 3'd4, 2'd0, 0, 0);
        code6(24'h246809, 3'd4, 3'd5, 2'd0, 0, 0);
        add(4'h2, 1, 0, 0, 3'd5, 3'd1, 2'd0, 0, 0);
        add(4'h4, 1, 0, 0, 3'd5, 3'd2, 2'd0, 0, 0);
        add(4'h6, 1, 0, 0, 3'd5, 3'd3, 2'd0, 0, 0);
        run_tbl();
        async_reset();

        code6(24'h611371, 3'd0, 3'd1, 2'd0, 0, 0);
        idle(0, 0, 3'd2, 2'd0, 0, 0);
        run_tbl();

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
